// File: rtl/debounce_pkg.sv
// Shared types for the keypad debouncer: qualify FSM states and counter sizing.
// Optional auto-repeat is enabled by DEBOUNCE_AUTO_REPEAT_EN; nothing here depends on it.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

   function automatic int cnt_width(input int stable);
      return $clog2(stable + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchronizer plus qualify FSM; edge to level/pulse is STABLE_CYCLES+2 clocks, no backpressure.
// DEBOUNCE_AUTO_REPEAT_EN adds a held-key repeat counter that emits extra press pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 8,
   parameter int ACTIVE_LOW    = 1
`ifdef DEBOUNCE_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int              CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic            IDLE_LVL = (ACTIVE_LOW != 0);

   logic          sync1, sync2, p;
   deb_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          level_n, press_n, release_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= IDLE_LVL;
         sync2 <= IDLE_LVL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Normalise polarity so p=1 always means pressed.
   assign p       = sync2 ^ IDLE_LVL;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

`ifdef DEBOUNCE_AUTO_REPEAT_EN
   localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW   = cnt_width(RMAX);
   localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt, rep_cnt_n;
   logic          rep_first, rep_first_n;
`endif

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      level_n   = level;
      press_n   = 1'b0;
      release_n = 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
      rep_cnt_n   = rep_cnt;
      rep_first_n = rep_first;
`endif
      case (state)
         IDLE: begin
            if (p) begin
               state_n = PRESS_WAIT;
               cnt_n   = CW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!p) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = PRESSED;
               cnt_n   = '0;
               level_n = 1'b1;
               press_n = 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
               rep_cnt_n   = '0;
               rep_first_n = 1'b0;
`endif
            end else begin
               cnt_n = cnt_inc;
            end
         end
         PRESSED: begin
            if (!p) begin
               state_n = RELEASE_WAIT;
               cnt_n   = CW'(1);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            end else if (rep_cnt == (rep_first ? RPER : RDLY)) begin
               press_n     = 1'b1;
               rep_cnt_n   = '0;
               rep_first_n = 1'b1;
            end else begin
               rep_cnt_n = rep_cnt + RW'(1);
`endif
            end
         end
         RELEASE_WAIT: begin
            // Repeat counter is frozen here so a brief lift resumes the cadence.
            if (p) begin
               state_n = PRESSED;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n   = IDLE;
               cnt_n     = '0;
               level_n   = 1'b0;
               release_n = 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
               rep_cnt_n   = '0;
               rep_first_n = 1'b0;
`endif
            end else begin
               cnt_n = cnt_inc;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
         rep_cnt       <= '0;
         rep_first     <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         level         <= level_n;
         press_pulse   <= press_n;
         release_pulse <= release_n;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
         rep_cnt       <= rep_cnt_n;
         rep_first     <= rep_first_n;
`endif
      end
   end

endmodule

// File: rtl/multi_key_debouncer.sv
// N independent key debouncers with an OR of pressed levels; STABLE_CYCLES+2 clocks edge-to-output, no backpressure.
// Auto-repeat press pulses are built only when DEBOUNCE_AUTO_REPEAT_EN is defined.
module multi_key_debouncer #(
   parameter int NUM_CH        = 10,
   parameter int STABLE_CYCLES = 8,
   parameter int ACTIVE_LOW    = 1,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic              any_pressed
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef DEBOUNCE_AUTO_REPEAT_EN
         ,
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .raw           (raw_in[i]),
         .level         (level_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

   assign any_pressed = |level_out;

endmodule
